column_wrapper: RTL and testbench
=================================

COLUMN_WRAPPER -- requirements
Module: column_wrapper

Interface
REQ-001 SHALL have parameters: numRows=128, rows in the column; numCols=1, columns; numAdcBits=4, ADC result width; numCfgBits=8, config field width.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Ports (clock and reset first):
- clk  in  1  system clock.
- nrst  in  1  asynchronous reset, asserted high.
- cfg  in  qracc_config_t  configuration.
- to_analog_o  out  to_analog_t  all controls to the analog column.
- from_analog_i  in  from_analog_t  SA_OUT[numCols] and ADC_OUT[(2^numAdcBits-1)*numCols].
- adc_out_o  out  [numCols][numAdcBits]  MAC result per column.
- mac_en_i  in  1  MAC mode enable.
- data_p_i  in  numRows  per-row positive input.
- data_n_i  in  numRows  per-row negative input.
- rq_wr_i  in  1  request type: 1=write, 0=read.
- rq_valid_i  in  1  request valid.
- rq_ready_o  out  1  request ready.
- rd_valid_o  out  1  read data valid.
- rd_data_o  out  numCols  read data.
- wr_data_i  in  numCols  write data.
- addr_i  in  clog2(numRows)  row address.

Function
REQ-004 Switch matrix SHALL be combinational per row r while mac_en_i=1: data_p_i[r]=1 gives VDR_SEL[r]=1; else data_n_i[r]=1 gives VSS_SEL[r]=1; else VRST_SEL[r]=1. Exactly one of the three SHALL be high, with positive taking priority.
REQ-005 While mac_en_i=0, VRST_SEL SHALL be all-ones and VDR_SEL/VSS_SEL all-zeros.
REQ-006 Every *B output (VDR_SELB, VSS_SELB, VRST_SELB, NFB, M2AB, R2AB) SHALL be the bitwise inverse of its true signal.
REQ-007 to_analog_o.CLK SHALL equal clk.
REQ-008 ADC path: M2A=mac_en_i and R2A=~mac_en_i. NF=1 when cfg.binary_cfg=0 (ternary), else NF=0.
REQ-009 Each cycle, for column c, adc_out_o[c] SHALL register the popcount of that column's 2^numAdcBits-1 thermometer bits, right-shifted by (numAdcBits - cfg.n_adc_bits_cfg).
- n_adc_bits_cfg of 0 or greater than numAdcBits SHALL be treated as numAdcBits.
- Latency is 1 cycle.
REQ-010 SRAM FSM states SHALL be IDLE, WRITE, PRECH, READ.
- rq_ready_o=1 only in IDLE with mac_en_i=0.
- A request is accepted on the clk edge where rq_valid_i && rq_ready_o; addr_i and wr_data_i are latched at that edge.
REQ-011 WRITE SHALL last 1 cycle: WL one-hot at the latched address, WRITE=1, WR_DATA=latched data, CSEL all-ones. Then return to IDLE.
REQ-012 Read SHALL take 2 cycles:
- PRECH for 1 cycle: PCH=1, WL=0.
- READ for 1 cycle: WL one-hot at the latched address, SAEN=1, CSEL all-ones; SA_OUT is captured into rd_data_o at the end of READ.
- Then return to IDLE.
REQ-013 rd_valid_o SHALL rise on the cycle after READ and stay high until the next accepted request. rd_data_o SHALL hold its value until the next read completes.
REQ-014 While mac_en_i=1: WL all-ones, PCH=0, WRITE=0, SAEN=0.
REQ-015 mac_en_i rising during a WRITE/PRECH/READ SHALL NOT abort it; MAC controls apply once the FSM is back in IDLE.
REQ-016 Outside the states above, WL, PCH, WRITE, SAEN and WR_DATA SHALL be 0.

Reset
REQ-017 nrst=1 SHALL immediately force: FSM=IDLE; adc_out_o=0; rd_data_o=0; rd_valid_o=0; latched address and data=0.
REQ-018 A reset asserted mid-transaction SHALL drop the transaction without a rd_valid_o pulse.

Structure
REQ-019 Package qracc_pkg SHALL hold to_analog_t, from_analog_t and qracc_config_t (n_input_bits_cfg, n_adc_bits_cfg, binary_cfg), sized by package constants for rows, cols and ADC bits.
REQ-020 The SRAM FSM SHALL be implemented as sub-module column_sram_ctrl; the switch matrix and ADC decode SHALL be inline.
REQ-021 Analog model ts_column SHALL be driven with the flattened to_analog_o fields.

Verification
REQ-022 Reset: nrst=1 -> adc_out_o=0, rd_valid_o=0, rq_ready_o=1 once nrst=0 and mac_en_i=0.
REQ-023 Write addr 5, data 1, then read addr 5 with SA_OUT=1 -> WL[5] pulses in WRITE and READ, PCH pulses 1 cycle, rd_data_o=1, rd_valid_o held high.
REQ-024 mac_en_i=1, data_p_i[5]=1, data_n_i[5]=1, data_n_i[6]=1 -> VDR_SEL[5]=1, VSS_SEL[6]=1, VRST_SEL elsewhere, rq_ready_o=0.
REQ-025 ADC_OUT=0x0007, n_adc_bits_cfg=4 -> adc_out_o=3 one cycle later; 0x7FFF gives 15; n_adc_bits_cfg=2 with 0x7FFF gives 3.
REQ-026 Sweep data_n_i from all-ones, shifting in zeros over 128 cycles, then sweep data_p_i shifting in ones -> the VSS-to-VRST-to-VDR row counts change by one per cycle with no overlapping selects.

Source files
------------

// File: rtl/qracc_pkg.sv
// Shared types and constants for the QR accelerator column: analog control
// bundle, analog return bundle, runtime configuration and SRAM FSM states.
package qracc_pkg;

  localparam int NUM_ROWS       = 128;
  localparam int NUM_COLS       = 1;
  localparam int NUM_ADC_BITS   = 4;
  localparam int NUM_CFG_BITS   = 8;
  localparam int ADC_THERM_BITS = (1 << NUM_ADC_BITS) - 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    PRECH,
    READ
  } sram_state_t;

  typedef struct packed {
    logic [NUM_CFG_BITS-1:0] n_input_bits_cfg;
    logic [NUM_CFG_BITS-1:0] n_adc_bits_cfg;
    logic                    binary_cfg;
  } qracc_config_t;

  typedef struct packed {
    logic                CLK;
    logic [NUM_ROWS-1:0] VDR_SEL;
    logic [NUM_ROWS-1:0] VDR_SELB;
    logic [NUM_ROWS-1:0] VSS_SEL;
    logic [NUM_ROWS-1:0] VSS_SELB;
    logic [NUM_ROWS-1:0] VRST_SEL;
    logic [NUM_ROWS-1:0] VRST_SELB;
    logic                NF;
    logic                NFB;
    logic                M2A;
    logic                M2AB;
    logic                R2A;
    logic                R2AB;
    logic [NUM_ROWS-1:0] WL;
    logic                PCH;
    logic [NUM_COLS-1:0] WR_DATA;
    logic                WRITE;
    logic [NUM_COLS-1:0] CSEL;
    logic                SAEN;
  } to_analog_t;

  typedef struct packed {
    logic [NUM_COLS-1:0]                SA_OUT;
    logic [ADC_THERM_BITS*NUM_COLS-1:0] ADC_OUT;
  } from_analog_t;

  // Number of set bits in one column's thermometer-coded comparator bank.
  function automatic logic [NUM_ADC_BITS-1:0] therm_count(
    input logic [ADC_THERM_BITS-1:0] therm
  );
    logic [NUM_ADC_BITS-1:0] n;
    n = '0;
    for (int i = 0; i < ADC_THERM_BITS; i++) begin
      n = n + NUM_ADC_BITS'(therm[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/column_sram_ctrl.sv
// SRAM access sequencer for the column: single-cycle writes, precharge +
// sense reads, and word-line override while the column is in MAC mode.
//
// state | meaning
// IDLE  | waiting for a request; WL all-ones when mac_en_i=1
// WRITE | WL at latched row, WRITE and WR_DATA driven, columns selected
// PRECH | bit lines precharged, all word lines off
// READ  | WL at latched row, sense amps enabled; SA_OUT captured on exit
module column_sram_ctrl
  import qracc_pkg::*;
#(
  parameter int numRows = NUM_ROWS,
  parameter int numCols = NUM_COLS
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       mac_en_i,
  input  logic                       rq_wr_i,
  input  logic                       rq_valid_i,
  output logic                       rq_ready_o,
  output logic                       rd_valid_o,
  output logic [numCols-1:0]         rd_data_o,
  input  logic [numCols-1:0]         wr_data_i,
  input  logic [$clog2(numRows)-1:0] addr_i,
  input  logic [numCols-1:0]         sa_out_i,
  output logic [numRows-1:0]         wl_o,
  output logic                       pch_o,
  output logic                       write_o,
  output logic                       saen_o,
  output logic [numCols-1:0]         wr_data_o,
  output logic [numCols-1:0]         csel_o
);

  sram_state_t                state, state_nxt;
  logic [$clog2(numRows)-1:0] addr_q;
  logic [numCols-1:0]         data_q;
  logic                       accept;

  assign accept = rq_valid_i && rq_ready_o;

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Request latch and read-result holding registers.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      addr_q     <= '0;
      data_q     <= '0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else if (accept) begin
      addr_q     <= addr_i;
      data_q     <= wr_data_i;
      rd_valid_o <= 1'b0;
    end else if (state == READ) begin
      rd_valid_o <= 1'b1;
      rd_data_o  <= sa_out_i;
    end
  end

  // Next state and array controls; an access already started runs to
  // completion even if MAC mode is requested meanwhile.
  always_comb begin
    state_nxt  = state;
    rq_ready_o = 1'b0;
    wl_o       = '0;
    pch_o      = 1'b0;
    write_o    = 1'b0;
    saen_o     = 1'b0;
    wr_data_o  = '0;
    csel_o     = '0;
    case (state)
      IDLE: begin
        rq_ready_o = !mac_en_i;
        if (mac_en_i) wl_o = '1;
        if (rq_valid_i && !mac_en_i) state_nxt = rq_wr_i ? WRITE : PRECH;
      end
      WRITE: begin
        wl_o[addr_q] = 1'b1;
        write_o      = 1'b1;
        wr_data_o    = data_q;
        csel_o       = '1;
        state_nxt    = IDLE;
      end
      PRECH: begin
        pch_o     = 1'b1;
        state_nxt = READ;
      end
      READ: begin
        wl_o[addr_q] = 1'b1;
        saen_o       = 1'b1;
        csel_o       = '1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/column_wrapper.sv
// Digital wrapper around one analog compute column: per-row input switch
// matrix, ADC thermometer decode with runtime resolution, SRAM sequencing.
module column_wrapper
  import qracc_pkg::*;
#(
  parameter int numRows    = NUM_ROWS,
  parameter int numCols    = NUM_COLS,
  parameter int numAdcBits = NUM_ADC_BITS,
  parameter int numCfgBits = NUM_CFG_BITS
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  qracc_config_t                       cfg,
  output to_analog_t                          to_analog_o,
  input  from_analog_t                        from_analog_i,
  output logic [numCols-1:0][numAdcBits-1:0]  adc_out_o,
  input  logic                                mac_en_i,
  input  logic [numRows-1:0]                  data_p_i,
  input  logic [numRows-1:0]                  data_n_i,
  input  logic                                rq_wr_i,
  input  logic                                rq_valid_i,
  output logic                                rq_ready_o,
  output logic                                rd_valid_o,
  output logic [numCols-1:0]                  rd_data_o,
  input  logic [numCols-1:0]                  wr_data_i,
  input  logic [$clog2(numRows)-1:0]          addr_i
);

  localparam int THERM_BITS = (1 << numAdcBits) - 1;

  logic [numRows-1:0]    vdr_sel, vss_sel, vrst_sel;
  logic [numRows-1:0]    wl;
  logic                  pch, write, saen;
  logic [numCols-1:0]    wr_data, csel;
  logic [numCfgBits-1:0] adc_bits_eff, adc_shift;
  logic                  unused_cfg;

  // Input precision is consumed by the sequencer above this column.
  assign unused_cfg = ^cfg.n_input_bits_cfg;

  column_sram_ctrl #(
    .numRows (numRows),
    .numCols (numCols)
  ) u_sram_ctrl (
    .clk        (clk),
    .nrst       (nrst),
    .mac_en_i   (mac_en_i),
    .rq_wr_i    (rq_wr_i),
    .rq_valid_i (rq_valid_i),
    .rq_ready_o (rq_ready_o),
    .rd_valid_o (rd_valid_o),
    .rd_data_o  (rd_data_o),
    .wr_data_i  (wr_data_i),
    .addr_i     (addr_i),
    .sa_out_i   (from_analog_i.SA_OUT),
    .wl_o       (wl),
    .pch_o      (pch),
    .write_o    (write),
    .saen_o     (saen),
    .wr_data_o  (wr_data),
    .csel_o     (csel)
  );

  // Row switch matrix: positive input wins, then negative, else reset level.
  always_comb begin
    vdr_sel  = '0;
    vss_sel  = '0;
    vrst_sel = '1;
    if (mac_en_i) begin
      vdr_sel  = data_p_i;
      vss_sel  = ~data_p_i & data_n_i;
      vrst_sel = ~data_p_i & ~data_n_i;
    end
  end

  // Out-of-range resolution settings fall back to full ADC resolution.
  always_comb begin
    adc_bits_eff = cfg.n_adc_bits_cfg;
    if (cfg.n_adc_bits_cfg == '0 ||
        cfg.n_adc_bits_cfg > numCfgBits'(numAdcBits)) begin
      adc_bits_eff = numCfgBits'(numAdcBits);
    end
    adc_shift = numCfgBits'(numAdcBits) - adc_bits_eff;
  end

  // Register the decoded, resolution-reduced ADC code of every column.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      adc_out_o <= '0;
    end else begin
      for (int c = 0; c < numCols; c++) begin
        adc_out_o[c] <= therm_count(
          from_analog_i.ADC_OUT[c*THERM_BITS +: THERM_BITS]) >> adc_shift;
      end
    end
  end

  // Assemble the analog control bundle, with complementary rails.
  always_comb begin
    to_analog_o           = '0;
    to_analog_o.CLK       = clk;
    to_analog_o.VDR_SEL   = vdr_sel;
    to_analog_o.VDR_SELB  = ~vdr_sel;
    to_analog_o.VSS_SEL   = vss_sel;
    to_analog_o.VSS_SELB  = ~vss_sel;
    to_analog_o.VRST_SEL  = vrst_sel;
    to_analog_o.VRST_SELB = ~vrst_sel;
    to_analog_o.NF        = ~cfg.binary_cfg;
    to_analog_o.NFB       = cfg.binary_cfg;
    to_analog_o.M2A       = mac_en_i;
    to_analog_o.M2AB      = ~mac_en_i;
    to_analog_o.R2A       = ~mac_en_i;
    to_analog_o.R2AB      = mac_en_i;
    to_analog_o.WL        = wl;
    to_analog_o.PCH       = pch;
    to_analog_o.WR_DATA   = wr_data;
    to_analog_o.WRITE     = write;
    to_analog_o.CSEL      = csel;
    to_analog_o.SAEN      = saen;
  end

endmodule

// File: tb/tb_column_wrapper.sv
// Directed bench for column_wrapper: reset, SRAM write/read sequencing,
// switch matrix, ADC decode, mode/reset interactions and row sweeps.
module tb_column_wrapper;
  import qracc_pkg::*;

  logic                                  clk;
  logic                                  nrst;
  qracc_config_t                         cfg;
  to_analog_t                            to_analog;
  from_analog_t                          from_analog;
  logic [NUM_COLS-1:0][NUM_ADC_BITS-1:0] adc_out;
  logic                                  mac_en;
  logic [NUM_ROWS-1:0]                   data_p, data_n;
  logic                                  rq_wr, rq_valid, rq_ready;
  logic                                  rd_valid;
  logic [NUM_COLS-1:0]                   rd_data, wr_data;
  logic [$clog2(NUM_ROWS)-1:0]           addr;

  int n_checks = 0;
  int n_fail   = 0;

  column_wrapper dut (
    .clk           (clk),
    .nrst          (nrst),
    .cfg           (cfg),
    .to_analog_o   (to_analog),
    .from_analog_i (from_analog),
    .adc_out_o     (adc_out),
    .mac_en_i      (mac_en),
    .data_p_i      (data_p),
    .data_n_i      (data_n),
    .rq_wr_i       (rq_wr),
    .rq_valid_i    (rq_valid),
    .rq_ready_o    (rq_ready),
    .rd_valid_o    (rd_valid),
    .rd_data_o     (rd_data),
    .wr_data_i     (wr_data),
    .addr_i        (addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b1;
    from_analog.ADC_OUT = 'h7FFF;
    tick();
    tick();
    n_checks++;
    if (adc_out[0] !== 4'd0) begin
      n_fail++; $display("FAIL reset_adc: got %0d want 0", adc_out[0]);
    end
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== 1'b0) begin
      n_fail++; $display("FAIL reset_rd: got valid=%b data=%b want 0 0", rd_valid, rd_data);
    end
    from_analog.ADC_OUT = '0;
    nrst = 1'b0;
    #1;
    n_checks++;
    if (rq_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", rq_ready);
    end
    tick();
  endtask

  task automatic test_write_read();
    logic [NUM_ROWS-1:0] wl5;
    wl5 = '0;
    wl5[5] = 1'b1;
    rq_valid = 1'b1; rq_wr = 1'b1; addr = 7'd5; wr_data = 1'b1;
    tick();
    rq_valid = 1'b0; addr = '0; wr_data = 1'b0;
    n_checks++;
    if (to_analog.WL !== wl5 || to_analog.WRITE !== 1'b1) begin
      n_fail++; $display("FAIL write_wl: got wl=%h write=%b want wl=%h write=1", to_analog.WL, to_analog.WRITE, wl5);
    end
    n_checks++;
    if (to_analog.WR_DATA !== 1'b1 || to_analog.CSEL !== 1'b1 || rq_ready !== 1'b0) begin
      n_fail++; $display("FAIL write_data: got wr_data=%b csel=%b ready=%b want 1 1 0", to_analog.WR_DATA, to_analog.CSEL, rq_ready);
    end
    tick();
    n_checks++;
    if (to_analog.WL !== '0 || to_analog.WRITE !== 1'b0 || rq_ready !== 1'b1) begin
      n_fail++; $display("FAIL write_done: got wl=%h write=%b ready=%b want 0 0 1", to_analog.WL, to_analog.WRITE, rq_ready);
    end
    rq_valid = 1'b1; rq_wr = 1'b0; addr = 7'd5;
    from_analog.SA_OUT = 1'b1;
    tick();
    rq_valid = 1'b0; addr = '0;
    n_checks++;
    if (to_analog.PCH !== 1'b1 || to_analog.WL !== '0 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL read_prech: got pch=%b wl=%h rd_valid=%b want 1 0 0", to_analog.PCH, to_analog.WL, rd_valid);
    end
    tick();
    n_checks++;
    if (to_analog.WL !== wl5 || to_analog.SAEN !== 1'b1 || to_analog.PCH !== 1'b0 || to_analog.CSEL !== 1'b1) begin
      n_fail++; $display("FAIL read_sense: got wl=%h saen=%b pch=%b csel=%b want wl=%h 1 0 1", to_analog.WL, to_analog.SAEN, to_analog.PCH, to_analog.CSEL, wl5);
    end
    tick();
    from_analog.SA_OUT = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 1'b1 || to_analog.SAEN !== 1'b0) begin
      n_fail++; $display("FAIL read_done: got valid=%b data=%b saen=%b want 1 1 0", rd_valid, rd_data, to_analog.SAEN);
    end
    tick(); tick(); tick();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 1'b1) begin
      n_fail++; $display("FAIL read_hold: got valid=%b data=%b want 1 1", rd_valid, rd_data);
    end
    rq_valid = 1'b1; rq_wr = 1'b1; addr = 7'd0; wr_data = 1'b0;
    tick();
    rq_valid = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== 1'b1) begin
      n_fail++; $display("FAIL valid_clear: got valid=%b data=%b want 0 1", rd_valid, rd_data);
    end
    tick();
  endtask

  task automatic test_mac();
    logic [NUM_ROWS-1:0] e_vdr, e_vss;
    e_vdr = '0; e_vdr[5] = 1'b1;
    e_vss = '0; e_vss[6] = 1'b1;
    mac_en = 1'b1;
    data_p = '0; data_p[5] = 1'b1;
    data_n = '0; data_n[5] = 1'b1; data_n[6] = 1'b1;
    cfg.binary_cfg = 1'b0;
    #1;
    n_checks++;
    if (to_analog.VDR_SEL !== e_vdr || to_analog.VSS_SEL !== e_vss) begin
      n_fail++; $display("FAIL mac_sel: got vdr=%h vss=%h want %h %h", to_analog.VDR_SEL, to_analog.VSS_SEL, e_vdr, e_vss);
    end
    n_checks++;
    if (to_analog.VRST_SEL !== ~(e_vdr | e_vss)) begin
      n_fail++; $display("FAIL mac_rst: got %h want %h", to_analog.VRST_SEL, ~(e_vdr | e_vss));
    end
    n_checks++;
    if (to_analog.VDR_SELB !== ~e_vdr || to_analog.VSS_SELB !== ~e_vss || to_analog.VRST_SELB !== (e_vdr | e_vss)) begin
      n_fail++; $display("FAIL mac_selb: got vdrb=%h vssb=%h vrstb=%h", to_analog.VDR_SELB, to_analog.VSS_SELB, to_analog.VRST_SELB);
    end
    n_checks++;
    if (rq_ready !== 1'b0 || to_analog.WL !== '1 || to_analog.PCH !== 1'b0 || to_analog.SAEN !== 1'b0) begin
      n_fail++; $display("FAIL mac_sram: got ready=%b wl=%h pch=%b saen=%b want 0 all-ones 0 0", rq_ready, to_analog.WL, to_analog.PCH, to_analog.SAEN);
    end
    n_checks++;
    if ({to_analog.M2A, to_analog.M2AB, to_analog.R2A, to_analog.R2AB, to_analog.NF, to_analog.NFB} !== 6'b100110) begin
      n_fail++; $display("FAIL mac_path: got m2a/m2ab/r2a/r2ab/nf/nfb=%b want 100110", {to_analog.M2A, to_analog.M2AB, to_analog.R2A, to_analog.R2AB, to_analog.NF, to_analog.NFB});
    end
    cfg.binary_cfg = 1'b1;
    mac_en = 1'b0;
    #1;
    n_checks++;
    if ({to_analog.M2A, to_analog.M2AB, to_analog.R2A, to_analog.R2AB, to_analog.NF, to_analog.NFB} !== 6'b011001) begin
      n_fail++; $display("FAIL idle_path: got m2a/m2ab/r2a/r2ab/nf/nfb=%b want 011001", {to_analog.M2A, to_analog.M2AB, to_analog.R2A, to_analog.R2AB, to_analog.NF, to_analog.NFB});
    end
    n_checks++;
    if (to_analog.VRST_SEL !== '1 || to_analog.VDR_SEL !== '0 || to_analog.VSS_SEL !== '0 || to_analog.WL !== '0) begin
      n_fail++; $display("FAIL idle_sel: got vrst=%h vdr=%h vss=%h wl=%h", to_analog.VRST_SEL, to_analog.VDR_SEL, to_analog.VSS_SEL, to_analog.WL);
    end
    cfg.binary_cfg = 1'b0;
    data_p = '0; data_n = '0;
    tick();
    n_checks++;
    if (to_analog.CLK !== 1'b1) begin
      n_fail++; $display("FAIL clk_high: got %b want 1", to_analog.CLK);
    end
    @(negedge clk); #1;
    n_checks++;
    if (to_analog.CLK !== 1'b0) begin
      n_fail++; $display("FAIL clk_low: got %b want 0", to_analog.CLK);
    end
    tick();
  endtask

  task automatic test_mac_during_write();
    logic [NUM_ROWS-1:0] wl9;
    wl9 = '0; wl9[9] = 1'b1;
    rq_valid = 1'b1; rq_wr = 1'b1; addr = 7'd9; wr_data = 1'b1;
    tick();
    rq_valid = 1'b0;
    mac_en = 1'b1;
    #1;
    n_checks++;
    if (to_analog.WL !== wl9 || to_analog.WRITE !== 1'b1) begin
      n_fail++; $display("FAIL mac_no_abort: got wl=%h write=%b want %h 1", to_analog.WL, to_analog.WRITE, wl9);
    end
    tick();
    n_checks++;
    if (to_analog.WL !== '1 || to_analog.WRITE !== 1'b0 || rq_ready !== 1'b0) begin
      n_fail++; $display("FAIL mac_after_write: got wl=%h write=%b ready=%b want all-ones 0 0", to_analog.WL, to_analog.WRITE, rq_ready);
    end
    mac_en = 1'b0;
    wr_data = 1'b0;
    tick();
  endtask

  task automatic test_adc();
    cfg.n_adc_bits_cfg = 8'd4;
    from_analog.ADC_OUT = 'h0007;
    #1;
    n_checks++;
    if (adc_out[0] !== 4'd0) begin
      n_fail++; $display("FAIL adc_latency: got %0d want 0", adc_out[0]);
    end
    tick();
    n_checks++;
    if (adc_out[0] !== 4'd3) begin
      n_fail++; $display("FAIL adc_7_n4: got %0d want 3", adc_out[0]);
    end
    from_analog.ADC_OUT = 'h7FFF;
    tick();
    n_checks++;
    if (adc_out[0] !== 4'd15) begin
      n_fail++; $display("FAIL adc_7fff_n4: got %0d want 15", adc_out[0]);
    end
    cfg.n_adc_bits_cfg = 8'd2;
    tick();
    n_checks++;
    if (adc_out[0] !== 4'd3) begin
      n_fail++; $display("FAIL adc_7fff_n2: got %0d want 3", adc_out[0]);
    end
    cfg.n_adc_bits_cfg = 8'd3;
    from_analog.ADC_OUT = 'h00FF;
    tick();
    n_checks++;
    if (adc_out[0] !== 4'd4) begin
      n_fail++; $display("FAIL adc_ff_n3: got %0d want 4", adc_out[0]);
    end
    cfg.n_adc_bits_cfg = 8'd0;
    from_analog.ADC_OUT = 'h1234;
    tick();
    n_checks++;
    if (adc_out[0] !== 4'd5) begin
      n_fail++; $display("FAIL adc_n0: got %0d want 5", adc_out[0]);
    end
    cfg.n_adc_bits_cfg = 8'd9;
    from_analog.ADC_OUT = 'h7FFF;
    tick();
    n_checks++;
    if (adc_out[0] !== 4'd15) begin
      n_fail++; $display("FAIL adc_n9: got %0d want 15", adc_out[0]);
    end
    cfg.n_adc_bits_cfg = 8'd1;
    tick();
    n_checks++;
    if (adc_out[0] !== 4'd1) begin
      n_fail++; $display("FAIL adc_n1: got %0d want 1", adc_out[0]);
    end
    cfg.n_adc_bits_cfg = 8'd4;
    tick();
  endtask

  task automatic test_reset_mid_read();
    rq_valid = 1'b1; rq_wr = 1'b0; addr = 7'd3;
    from_analog.SA_OUT = 1'b1;
    tick();
    rq_valid = 1'b0;
    n_checks++;
    if (to_analog.PCH !== 1'b1 || adc_out[0] !== 4'd15) begin
      n_fail++; $display("FAIL pre_reset: got pch=%b adc=%0d want 1 15", to_analog.PCH, adc_out[0]);
    end
    nrst = 1'b1;
    #1;
    n_checks++;
    if (to_analog.PCH !== 1'b0 || adc_out[0] !== 4'd0 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got pch=%b adc=%0d rd_valid=%b want 0 0 0", to_analog.PCH, adc_out[0], rd_valid);
    end
    tick();
    nrst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (rd_valid !== 1'b0 || to_analog.SAEN !== 1'b0 || rd_data !== 1'b0) begin
        n_fail++; $display("FAIL dropped_read cycle %0d: got valid=%b saen=%b data=%b want 0 0 0", i, rd_valid, to_analog.SAEN, rd_data);
      end
    end
    from_analog.SA_OUT = 1'b0;
    from_analog.ADC_OUT = '0;
  endtask

  task automatic test_sweep();
    int e_vdr, e_vss, e_vrst;
    mac_en = 1'b1;
    data_p = '0;
    data_n = '1;
    for (int i = 0; i <= NUM_ROWS; i++) begin
      #1;
      e_vss = NUM_ROWS - i; e_vrst = i; e_vdr = 0;
      n_checks++;
      if ($countones(to_analog.VSS_SEL) !== e_vss || $countones(to_analog.VRST_SEL) !== e_vrst ||
          $countones(to_analog.VDR_SEL) !== e_vdr) begin
        n_fail++; $display("FAIL sweep_n step %0d: got vdr/vss/vrst=%0d/%0d/%0d want %0d/%0d/%0d", i,
          $countones(to_analog.VDR_SEL), $countones(to_analog.VSS_SEL), $countones(to_analog.VRST_SEL), e_vdr, e_vss, e_vrst);
      end
      n_checks++;
      if (((to_analog.VDR_SEL & to_analog.VSS_SEL) | (to_analog.VDR_SEL & to_analog.VRST_SEL) |
           (to_analog.VSS_SEL & to_analog.VRST_SEL)) !== '0 ||
          (to_analog.VDR_SEL | to_analog.VSS_SEL | to_analog.VRST_SEL) !== '1) begin
        n_fail++; $display("FAIL sweep_n_onehot step %0d: got vdr=%h vss=%h vrst=%h", i, to_analog.VDR_SEL, to_analog.VSS_SEL, to_analog.VRST_SEL);
      end
      data_n = data_n << 1;
      tick();
    end
    for (int i = 0; i <= NUM_ROWS; i++) begin
      #1;
      e_vdr = i; e_vrst = NUM_ROWS - i; e_vss = 0;
      n_checks++;
      if ($countones(to_analog.VSS_SEL) !== e_vss || $countones(to_analog.VRST_SEL) !== e_vrst ||
          $countones(to_analog.VDR_SEL) !== e_vdr) begin
        n_fail++; $display("FAIL sweep_p step %0d: got vdr/vss/vrst=%0d/%0d/%0d want %0d/%0d/%0d", i,
          $countones(to_analog.VDR_SEL), $countones(to_analog.VSS_SEL), $countones(to_analog.VRST_SEL), e_vdr, e_vss, e_vrst);
      end
      n_checks++;
      if (((to_analog.VDR_SEL & to_analog.VSS_SEL) | (to_analog.VDR_SEL & to_analog.VRST_SEL) |
           (to_analog.VSS_SEL & to_analog.VRST_SEL)) !== '0 ||
          (to_analog.VDR_SEL | to_analog.VSS_SEL | to_analog.VRST_SEL) !== '1) begin
        n_fail++; $display("FAIL sweep_p_onehot step %0d: got vdr=%h vss=%h vrst=%h", i, to_analog.VDR_SEL, to_analog.VSS_SEL, to_analog.VRST_SEL);
      end
      data_p = {data_p[NUM_ROWS-2:0], 1'b1};
      tick();
    end
    mac_en = 1'b0;
    data_p = '0;
    tick();
  endtask

  initial begin
    nrst        = 1'b1;
    cfg         = '0;
    cfg.n_input_bits_cfg = 8'd4;
    cfg.n_adc_bits_cfg   = 8'd4;
    from_analog = '0;
    mac_en      = 1'b0;
    data_p      = '0;
    data_n      = '0;
    rq_wr       = 1'b0;
    rq_valid    = 1'b0;
    wr_data     = '0;
    addr        = '0;

    test_reset();
    test_write_read();
    test_mac();
    test_mac_during_write();
    test_adc();
    test_reset_mid_read();
    test_sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
